// File: rtl/rf_sched_pkg.sv
// Shared widths, default starvation bound and grant encoding for the
// register-file write scheduler.
package rf_sched_pkg;

  localparam int REG_AW           = 5;
  localparam int XLEN             = 32;
  localparam int NREGS            = 32;
  localparam int DEFAULT_MAX_WAIT = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_MDU  = 2'd2
  } gnt_e;

  // A write to x0 completes its handshake but never reaches the register file.
  function automatic logic writes_rf(input logic [REG_AW-1:0] rd);
    return rd != {REG_AW{1'b0}};
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for outstanding MDU destinations, with the hazard
// and issue lookups decode needs. x0 can never become busy.
module rf_scoreboard
  import rf_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en_i,
  input  logic [REG_AW-1:0] set_idx_i,
  input  logic              clr_en_i,
  input  logic [REG_AW-1:0] clr_idx_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [REG_AW-1:0] iss_idx_i,
  output logic [NREGS-1:0]  busy_o,
  output logic              rs1_hazard_o,
  output logic              rs2_hazard_o,
  output logic              iss_free_o
);

  localparam logic [NREGS-1:0] ONE_HOT_0 = {{(NREGS-1){1'b0}}, 1'b1};

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] set_mask_s;
  logic [NREGS-1:0] clr_mask_s;

  // Next busy vector: clear first, then set, so a same-edge set of the same
  // register wins; bit 0 is masked off unconditionally.
  always_comb begin
    set_mask_s = {NREGS{1'b0}};
    clr_mask_s = {NREGS{1'b0}};
    if (set_en_i) begin
      set_mask_s = ONE_HOT_0 << set_idx_i;
    end else begin
      set_mask_s = {NREGS{1'b0}};
    end
    if (clr_en_i) begin
      clr_mask_s = ONE_HOT_0 << clr_idx_i;
    end else begin
      clr_mask_s = {NREGS{1'b0}};
    end
    busy_d = ((busy_q & ~clr_mask_s) | set_mask_s) & ~ONE_HOT_0;
  end

  // Busy vector register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= {NREGS{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o       = busy_q;
  assign rs1_hazard_o = (rs1_i != {REG_AW{1'b0}}) & busy_q[rs1_i];
  assign rs2_hazard_o = (rs2_i != {REG_AW{1'b0}}) & busy_q[rs2_i];
  assign iss_free_o   = ~busy_q[iss_idx_i];

endmodule

// File: rtl/rf_write_scheduler.sv
// Arbitrates the register-file write port between pipeline writeback and the
// MDU result path. Writeback normally has priority, but a writeback whose
// destination is still owed by the MDU must wait, and an MDU result refused
// MAX_WAIT cycles in a row is forced through for one grant.
module rf_write_scheduler
  import rf_sched_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              wb_ready,
  input  logic              mdu_valid,
  input  logic [REG_AW-1:0] mdu_rd,
  input  logic [XLEN-1:0]   mdu_data,
  output logic              mdu_ready,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  output logic              iss_ready,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              rs1_hazard,
  output logic              rs2_hazard,
  output logic [NREGS-1:0]  busy,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_wdata
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [NREGS-1:0]  busy_s;
  logic              iss_free_s;
  logic              iss_fire_s;
  logic              wb_elig_s;
  logic              force_s;
  gnt_e              gnt_s;
  logic [3:0]        wait_cnt_q;
  logic [3:0]        wait_cnt_d;
  logic              rf_we_q;
  logic              rf_we_d;
  logic [REG_AW-1:0] rf_rd_q;
  logic [REG_AW-1:0] rf_rd_d;
  logic [XLEN-1:0]   rf_wdata_q;
  logic [XLEN-1:0]   rf_wdata_d;

  rf_scoreboard u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .set_en_i     (iss_fire_s),
    .set_idx_i    (iss_rd),
    .clr_en_i     (mdu_ready),
    .clr_idx_i    (mdu_rd),
    .rs1_i        (rs1),
    .rs2_i        (rs2),
    .iss_idx_i    (iss_rd),
    .busy_o       (busy_s),
    .rs1_hazard_o (rs1_hazard),
    .rs2_hazard_o (rs2_hazard),
    .iss_free_o   (iss_free_s)
  );

  // A busy destination means an older MDU result is still owed to it.
  assign wb_elig_s  = wb_valid & ~busy_s[wb_rd];
  assign force_s    = (wait_cnt_q == MAX_WAIT_C);
  assign iss_ready  = rst_n & iss_free_s;
  assign iss_fire_s = iss_valid & iss_ready;

  // Grant selection: MDU when writeback cannot use the port or the MDU has
  // starved long enough; nothing is granted while reset is held.
  always_comb begin
    gnt_s = GNT_NONE;
    if (!rst_n) begin
      gnt_s = GNT_NONE;
    end else if (mdu_valid && (!wb_elig_s || force_s)) begin
      gnt_s = GNT_MDU;
    end else if (wb_elig_s) begin
      gnt_s = GNT_WB;
    end else begin
      gnt_s = GNT_NONE;
    end
  end

  assign wb_ready  = (gnt_s == GNT_WB);
  assign mdu_ready = (gnt_s == GNT_MDU);

  // Consecutive-refusal counter for a pending MDU result, saturating at the bound.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!mdu_valid || (gnt_s == GNT_MDU)) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Next write-port contents: load the winner, otherwise drop we and hold the rest.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    case (gnt_s)
      GNT_WB: begin
        rf_we_d    = writes_rf(wb_rd);
        rf_rd_d    = wb_rd;
        rf_wdata_d = wb_data;
      end
      GNT_MDU: begin
        rf_we_d    = writes_rf(mdu_rd);
        rf_rd_d    = mdu_rd;
        rf_wdata_d = mdu_data;
      end
      default: begin
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
      end
    endcase
  end

  // Wait counter and registered write port, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= 4'd0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= {REG_AW{1'b0}};
      rf_wdata_q <= {XLEN{1'b0}};
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign busy     = busy_s;
  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed scenarios plus a randomized run against a queue-based model of the
// write scheduler. Inputs change 1 time unit after the rising edge;
// combinational outputs are sampled 1 unit later, registered outputs right
// after the edge.
module tb_rf_write_scheduler;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, mdu_valid, iss_valid;
  logic [4:0]  wb_rd, mdu_rd, iss_rd, rs1, rs2;
  logic [31:0] wb_data, mdu_data;
  logic        wb_ready, mdu_ready, iss_ready, rs1_hazard, rs2_hazard;
  logic [31:0] busy;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_write_scheduler #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1(rs1), .rs2(rs2), .rs1_hazard(rs1_hazard), .rs2_hazard(rs2_hazard),
    .busy(busy), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
    iss_valid = 1'b0; iss_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid = 1'b1; iss_rd = rd;
    tick();
    iss_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h1111_1111;
    mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 32'h2222_2222;
    iss_valid = 1'b1; iss_rd = 5'd6; rs1 = 5'd6; rs2 = 5'd4;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({wb_ready, mdu_ready, iss_ready} !== 3'b000) begin
        errors++; $display("FAIL reset_readies cyc=%0d got=%b exp=000", i, {wb_ready, mdu_ready, iss_ready});
      end
      tick();
    end
    checks++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0) begin
      errors++; $display("FAIL reset_port got we=%b rd=%0d wd=%h exp 0/0/0", rf_we, rf_rd, rf_wdata);
    end
    idle_inputs();
    rst_n = 1'b1;
    #1;
    checks++;
    if (busy !== 32'd0) begin
      errors++; $display("FAIL reset_busy got=%h exp=0", busy);
    end
    tick();
  endtask

  task automatic test_hazard();
    iss_valid = 1'b1; iss_rd = 5'd5;
    #1;
    checks++;
    if (iss_ready !== 1'b1) begin errors++; $display("FAIL hz_iss_ready got=%b exp=1", iss_ready); end
    tick();
    iss_valid = 1'b0; rs1 = 5'd5; rs2 = 5'd5; iss_rd = 5'd5;
    #1;
    checks++;
    if (rs1_hazard !== 1'b1 || rs2_hazard !== 1'b1 || busy[5] !== 1'b1) begin
      errors++; $display("FAIL hz_set got h1=%b h2=%b busy5=%b exp 1/1/1", rs1_hazard, rs2_hazard, busy[5]);
    end
    checks++;
    if (iss_ready !== 1'b0) begin errors++; $display("FAIL hz_waw_stall got=%b exp=0", iss_ready); end
    mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (mdu_ready !== 1'b1) begin errors++; $display("FAIL hz_mdu_ready got=%b exp=1", mdu_ready); end
    tick();
    mdu_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL hz_write got we=%b rd=%0d wd=%h exp 1/5/deadbeef", rf_we, rf_rd, rf_wdata);
    end
    checks++;
    if (rs1_hazard !== 1'b0 || busy[5] !== 1'b0) begin
      errors++; $display("FAIL hz_clear got h1=%b busy5=%b exp 0/0", rs1_hazard, busy[5]);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_starvation();
    logic [4:0] exp_rd;
    issue(5'd7);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0033;
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h0000_0077;
    for (int c = 0; c <= MW + 2; c++) begin
      #1;
      checks++;
      if (mdu_ready !== (c == MW) || wb_ready !== (c != MW)) begin
        errors++; $display("FAIL starve_gnt cyc=%0d got mdu=%b wb=%b exp mdu=%b", c, mdu_ready, wb_ready, (c == MW));
      end
      tick();
      exp_rd = (c == MW) ? 5'd7 : 5'd3;
      checks++;
      if (rf_we !== 1'b1 || rf_rd !== exp_rd) begin
        errors++; $display("FAIL starve_port cyc=%0d got we=%b rd=%0d exp 1/%0d", c, rf_we, rf_rd, exp_rd);
      end
      if (c == MW) mdu_valid = 1'b0;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_waw_order();
    issue(5'd9);
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'hAAAA_0009;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'hBBBB_0009;
    #1;
    checks++;
    if (mdu_ready !== 1'b1 || wb_ready !== 1'b0) begin
      errors++; $display("FAIL waw_first got mdu=%b wb=%b exp 1/0", mdu_ready, wb_ready);
    end
    tick();
    mdu_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_wdata !== 32'hBBBB_0009) begin
      errors++; $display("FAIL waw_mdu_write got we=%b rd=%0d wd=%h exp 1/9/bbbb0009", rf_we, rf_rd, rf_wdata);
    end
    #1;
    checks++;
    if (wb_ready !== 1'b1) begin errors++; $display("FAIL waw_wb_next got=%b exp=1", wb_ready); end
    tick();
    wb_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_wdata !== 32'hAAAA_0009) begin
      errors++; $display("FAIL waw_wb_write got we=%b rd=%0d wd=%h exp 1/9/aaaa0009", rf_we, rf_rd, rf_wdata);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_1234;
    #1;
    checks++;
    if (wb_ready !== 1'b1) begin errors++; $display("FAIL x0_wb_ready got=%b exp=1", wb_ready); end
    tick();
    wb_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b0 || rf_wdata !== 32'h0000_1234) begin
      errors++; $display("FAIL x0_no_we got we=%b wd=%h exp 0/00001234", rf_we, rf_wdata);
    end
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    checks++;
    if (iss_ready !== 1'b1) begin errors++; $display("FAIL x0_iss_ready got=%b exp=1", iss_ready); end
    tick();
    iss_valid = 1'b0;
    checks++;
    if (busy !== 32'd0) begin errors++; $display("FAIL x0_busy got=%h exp=0", busy); end
  endtask

  task automatic test_same_edge();
    mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 32'h0C0C_0C0C;
    iss_valid = 1'b1; iss_rd = 5'd12;
    #1;
    checks++;
    if (mdu_ready !== 1'b1 || iss_ready !== 1'b1) begin
      errors++; $display("FAIL same_edge_hs got mdu=%b iss=%b exp 1/1", mdu_ready, iss_ready);
    end
    tick();
    mdu_valid = 1'b0; iss_valid = 1'b0;
    checks++;
    if (busy !== 32'h0000_1000 || rf_rd !== 5'd12) begin
      errors++; $display("FAIL same_edge_set got busy=%h rd=%0d exp 00001000/12", busy, rf_rd);
    end
    mdu_valid = 1'b1;
    tick();
    mdu_valid = 1'b0;
    checks++;
    if (busy !== 32'd0) begin errors++; $display("FAIL same_edge_clear got=%h exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    issue(5'd7);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0303;
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h0000_0707;
    tick();
    tick();
    rst_n = 1'b0; iss_valid = 1'b1; iss_rd = 5'd4;
    #1;
    checks++;
    if ({wb_ready, mdu_ready, iss_ready} !== 3'b000) begin
      errors++; $display("FAIL midrst_readies got=%b exp=000", {wb_ready, mdu_ready, iss_ready});
    end
    tick();
    checks++;
    if (busy !== 32'd0 || rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0) begin
      errors++; $display("FAIL midrst_state got busy=%h we=%b rd=%0d wd=%h exp all 0", busy, rf_we, rf_rd, rf_wdata);
    end
    rst_n = 1'b1; iss_valid = 1'b0;
    for (int c = 0; c <= MW; c++) begin
      #1;
      checks++;
      if (mdu_ready !== (c == MW)) begin
        errors++; $display("FAIL midrst_wait cyc=%0d got mdu=%b exp=%b", c, mdu_ready, (c == MW));
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    bit [31:0]   m_busy;
    int          m_refused;
    bit          m_we;
    bit [4:0]    m_rd;
    bit [31:0]   m_wdata;
    bit [4:0]    pend_q[$];
    bit          wb_ok, e_mdu, e_wb, e_iss, e_h1, e_h2;
    rst_n = 1'b0; idle_inputs();
    tick();
    rst_n = 1'b1;
    m_busy = 32'd0; m_refused = 0; m_we = 1'b0; m_rd = 5'd0; m_wdata = 32'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++;
      if (busy !== m_busy || rf_we !== m_we || rf_rd !== m_rd || rf_wdata !== m_wdata) begin
        errors++; $display("FAIL rnd_state cyc=%0d got busy=%h we=%b rd=%0d wd=%h exp busy=%h we=%b rd=%0d wd=%h",
                           cyc, busy, rf_we, rf_rd, rf_wdata, m_busy, m_we, m_rd, m_wdata);
      end
      if (!wb_valid && ($urandom_range(0, 1) == 1)) begin
        wb_valid = 1'b1; wb_rd = 5'($urandom_range(0, 15)); wb_data = $urandom;
      end
      if (!mdu_valid && pend_q.size() > 0 && ($urandom_range(0, 1) == 1)) begin
        mdu_valid = 1'b1; mdu_rd = pend_q[0]; mdu_data = $urandom;
      end
      if (!iss_valid && ($urandom_range(0, 2) == 0)) begin
        iss_valid = 1'b1; iss_rd = 5'($urandom_range(0, 15));
      end
      rs1 = 5'($urandom_range(0, 15));
      rs2 = 5'($urandom_range(0, 15));
      #1;
      wb_ok = wb_valid && !m_busy[wb_rd];
      e_mdu = mdu_valid && (!wb_ok || (m_refused == MW));
      e_wb  = !e_mdu && wb_ok;
      e_iss = !m_busy[iss_rd];
      e_h1  = (rs1 != 5'd0) && m_busy[rs1];
      e_h2  = (rs2 != 5'd0) && m_busy[rs2];
      checks++;
      if (wb_ready !== e_wb || mdu_ready !== e_mdu || iss_ready !== e_iss || rs1_hazard !== e_h1 || rs2_hazard !== e_h2) begin
        errors++; $display("FAIL rnd_comb cyc=%0d got wb=%b mdu=%b iss=%b h1=%b h2=%b exp wb=%b mdu=%b iss=%b h1=%b h2=%b",
                           cyc, wb_ready, mdu_ready, iss_ready, rs1_hazard, rs2_hazard, e_wb, e_mdu, e_iss, e_h1, e_h2);
      end
      m_we = 1'b0;
      if (e_mdu) begin
        m_busy[mdu_rd] = 1'b0;
        void'(pend_q.pop_front());
        m_refused = 0;
        m_we = (mdu_rd != 5'd0); m_rd = mdu_rd; m_wdata = mdu_data;
      end else begin
        m_refused = mdu_valid ? ((m_refused < MW) ? m_refused + 1 : MW) : 0;
      end
      if (e_wb) begin
        m_we = (wb_rd != 5'd0); m_rd = wb_rd; m_wdata = wb_data;
      end
      if (iss_valid && e_iss && iss_rd != 5'd0) begin
        m_busy[iss_rd] = 1'b1;
        pend_q.push_back(iss_rd);
      end
      tick();
      if (e_mdu) mdu_valid = 1'b0;
      if (e_wb) wb_valid = 1'b0;
      if (iss_valid && e_iss) iss_valid = 1'b0;
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_hazard();
    test_starvation();
    test_waw_order();
    test_x0();
    test_same_edge();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
